// File: rtl/ov_pkg.sv
// ov_pkg: shared state encoding, default limits and helpers for the OV capture path
package ov_pkg;
  typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_FRAME, S_LINE} state_e;
  localparam int unsigned MAX_PCLK_DEF   = 1280;
  localparam int unsigned MAX_LINE_DEF   = 480;
  localparam int unsigned TIMEOUT_US_DEF = 1000;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/ov_sync.sv
// ov_sync: 2-flop synchroniser plus edge detect for the OV sensor bus
module ov_sync (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       pclk_i,
  input  logic       href_i,
  input  logic       vsync_i,
  input  logic [7:0] data_i,
  output logic       pe_o,
  output logic       href_o,
  output logic       href_rise_o,
  output logic       href_fall_o,
  output logic       vsync_o,
  output logic       vsync_rise_o,
  output logic       vsync_fall_o,
  output logic [7:0] data_o
);
  logic [10:0] s1_q, s2_q;
  logic [2:0]  s3_q;
  // all bus bits share one synchroniser so data stays aligned with the pclk edge
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= {data_i, vsync_i, href_i, pclk_i};
      s2_q <= s1_q;
      s3_q <= s2_q[2:0];
    end
  end
  assign pe_o         = s2_q[0] & ~s3_q[0];
  assign href_o       = s2_q[1];
  assign href_rise_o  = s2_q[1] & ~s3_q[1];
  assign href_fall_o  = ~s2_q[1] & s3_q[1];
  assign vsync_o      = s2_q[2];
  assign vsync_rise_o = s2_q[2] & ~s3_q[2];
  assign vsync_fall_o = ~s2_q[2] & s3_q[2];
  assign data_o       = s2_q[10:3];
endmodule

// File: rtl/ov_capture.sv
// ov_capture: oversampled OV sensor capture with line/byte tagging, overflow and loss detection
module ov_capture
  import ov_pkg::*;
#(
  parameter int unsigned MAX_PCLK   = MAX_PCLK_DEF,
  parameter int unsigned MAX_LINE   = MAX_LINE_DEF,
  parameter int unsigned TIMEOUT_US = TIMEOUT_US_DEF
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        pluse_us,
  input  logic        cap_en,
  input  logic        ov_pclk,
  input  logic        ov_href,
  input  logic        ov_vsync,
  input  logic [7:0]  ov_data,
  output logic [7:0]  data_pclk,
  output logic        data_vld,
  output logic [15:0] num_pclk,
  output logic [15:0] num_line,
  output logic        frame_done,
  output logic [15:0] line_len,
  output logic        ov_lost,
  output logic        ovf_err
);
  localparam logic [15:0] MP = 16'(MAX_PCLK);
  localparam logic [15:0] ML = 16'(MAX_LINE);
  localparam logic [15:0] TO = 16'(TIMEOUT_US);
  logic        pe, href, href_rise, href_fall, vsync, vsync_rise, vsync_fall;
  logic [7:0]  data;
  state_e      state_q;
  logic [15:0] byte_q, line_q, us_q, npclk_q, nline_q, len_q;
  logic [7:0]  data_q;
  logic        vld_q, fd_q, lost_q, ovf_q;
  logic        at_to, tmo, cap, keep;
  ov_sync u_sync (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .pclk_i       (ov_pclk),
    .href_i       (ov_href),
    .vsync_i      (ov_vsync),
    .data_i       (ov_data),
    .pe_o         (pe),
    .href_o       (href),
    .href_rise_o  (href_rise),
    .href_fall_o  (href_fall),
    .vsync_o      (vsync),
    .vsync_rise_o (vsync_rise),
    .vsync_fall_o (vsync_fall),
    .data_o       (data)
  );
  // a pclk edge coinciding with href fall still belongs to the closing line
  always_comb begin
    at_to = (us_q == TO);
    tmo   = at_to & ~pe;
    cap   = pe & (href | href_fall);
    keep  = (byte_q < MP) && (line_q < ML);
  end
  // pclk watchdog: µs counter restarted by every pclk edge
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      us_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      us_q   <= pe ? '0 : (pluse_us && !at_to) ? us_q + 16'd1 : us_q;
      lost_q <= pe ? 1'b0 : tmo ? 1'b1 : lost_q;
    end
  end
  // frame/line FSM with counters and registered outputs
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      line_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      npclk_q <= '0;
      nline_q <= '0;
      fd_q    <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
      if (tmo) state_q <= S_IDLE;
      else begin
        case (state_q)
          S_IDLE: if (vsync) state_q <= S_VSYNC;
          S_VSYNC: if (vsync_fall) begin
            state_q <= cap_en ? S_FRAME : S_IDLE;
            if (cap_en) begin
              line_q <= '0;
              byte_q <= '0;
              ovf_q  <= 1'b0;
            end
          end
          S_FRAME: begin
            if (vsync_rise) begin
              fd_q    <= 1'b1;
              state_q <= S_VSYNC;
            end else if (href_rise) begin
              byte_q  <= '0;
              state_q <= S_LINE;
            end
          end
          S_LINE: begin
            if (cap) begin
              if (keep) begin
                vld_q   <= 1'b1;
                data_q  <= data;
                npclk_q <= byte_q;
                nline_q <= line_q;
              end else ovf_q <= 1'b1;
              byte_q <= sat_inc(byte_q);
            end
            if (href_fall || vsync_rise) begin
              len_q   <= cap ? sat_inc(byte_q) : byte_q;
              line_q  <= sat_inc(line_q);
              fd_q    <= vsync_rise;
              state_q <= vsync_rise ? S_VSYNC : S_FRAME;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
  assign data_pclk  = data_q;
  assign data_vld   = vld_q;
  assign num_pclk   = npclk_q;
  assign num_line   = nline_q;
  assign frame_done = fd_q;
  assign line_len   = len_q;
  assign ov_lost    = lost_q;
  assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_ov_capture.sv
// tb_ov_capture: table-driven and randomized checks of ov_capture against a transaction-level model
module tb_ov_capture;
  import ov_pkg::*;
  localparam int MAXP = MAX_PCLK_DEF;
  localparam int MAXL = MAX_LINE_DEF;
  localparam int TOUS = TIMEOUT_US_DEF;
  logic clk_sys = 0, rst = 1, pluse_us = 0, cap_en = 0;
  logic ov_pclk = 0, ov_href = 0, ov_vsync = 0;
  logic [7:0] ov_data = 0;
  logic [7:0] data_pclk;
  logic data_vld, frame_done, ov_lost, ovf_err;
  logic [15:0] num_pclk, num_line, line_len;
  ov_capture dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .cap_en(cap_en),
    .ov_pclk(ov_pclk), .ov_href(ov_href), .ov_vsync(ov_vsync), .ov_data(ov_data),
    .data_pclk(data_pclk), .data_vld(data_vld), .num_pclk(num_pclk), .num_line(num_line),
    .frame_done(frame_done), .line_len(line_len), .ov_lost(ov_lost), .ovf_err(ovf_err)
  );
  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  initial forever begin
    @(negedge clk_sys);
    pluse_us = (cyc % 4 == 0);
  end
  typedef struct {logic [7:0] d; logic [15:0] p; logic [15:0] l; int t;} exp_t;
  typedef struct {int lines; int bytes; bit cs; bit cm; bit vh; int strobes; int len; int fd; bit ovf;} vec_t;
  exp_t vq[$];
  int fq[$];
  int n_cmp = 0, n_err = 0, vld_cnt = 0, fd_cnt = 0;
  bit m_cap = 0, mh = 0, mv = 0, m_ovf = 0;
  int m_line = 0, m_bidx = 0, m_len = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got a strobe expected none (cycle %0d)", nm, cyc);
  endtask
  // output monitor: every strobe must match the next modelled event, including its cycle
  initial begin
    bit pv;
    exp_t e;
    int ft;
    pv = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (data_vld) begin
        vld_cnt++;
        chk("vld_gap", {63'b0, pv}, 64'd0);
        if (vq.size() == 0) unexpected("vld_unexpected");
        else begin
          e = vq.pop_front();
          chk("vld_data", data_pclk, e.d);
          chk("vld_idx", {num_line, num_pclk}, {e.l, e.p});
          chk("vld_latency", cyc, e.t);
        end
      end
      pv = data_vld;
      if (frame_done) begin
        fd_cnt++;
        if (fq.size() == 0) unexpected("fd_unexpected");
        else begin
          ft = fq.pop_front();
          chk("fd_latency", cyc, ft);
        end
      end
    end
  end
  task automatic close_line();
    m_len = m_bidx;
    m_line++;
  endtask
  // one sensor pclk period (8 clk_sys); the model follows the sensor-side rules
  task automatic pcyc(input bit h, input bit v, input logic [7:0] d);
    exp_t e;
    if (v && !mv) begin
      if (m_cap) begin
        if (mh) close_line();
        fq.push_back(cyc + 3);
      end
      m_cap = 0;
    end else if (!v && mv) begin
      m_cap = cap_en;
      m_line = 0;
      if (cap_en) m_ovf = 0;
    end else if (m_cap && mh && !h) close_line();
    if (m_cap && !mh && h) m_bidx = 0;
    mh = h;
    mv = v;
    ov_pclk = 0;
    ov_href = h;
    ov_vsync = v;
    ov_data = d;
    repeat (4) @(negedge clk_sys);
    ov_pclk = 1;
    if (h && !v && m_cap) begin
      if (m_bidx < MAXP && m_line < MAXL) begin
        e.d = d;
        e.p = 16'(m_bidx);
        e.l = 16'(m_line);
        e.t = cyc + 3;
        vq.push_back(e);
      end else m_ovf = 1;
      m_bidx++;
    end
    repeat (4) @(negedge clk_sys);
  endtask
  task automatic run_frame(input int lines, input int bytes, input bit cs, input bit cm, input bit vh, input bit rnd);
    cap_en = cs;
    pcyc(0, 1, 0);
    pcyc(0, 1, 0);
    pcyc(0, 0, 0);
    for (int l = 0; l < lines; l++) begin
      if (l == 1) cap_en = cm;
      for (int b = 0; b < bytes; b++) pcyc(1, 0, rnd ? 8'($urandom) : 8'(16 + l * bytes + b));
      if (!(vh && l == lines - 1)) begin
        pcyc(0, 0, 0);
        pcyc(0, 0, 0);
      end
    end
    pcyc(0, 1, 0);
    pcyc(0, 1, 0);
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, {4'b0, data_pclk, data_vld, num_pclk, num_line, frame_done, line_len, ov_lost, ovf_err}, 64'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1);
  end
  initial begin
    vec_t tbl[6];
    int v0, f0, nl, nb;
    bit cs, cm, vh;
    tbl[0] = '{2, 4, 1, 1, 0, 8, 4, 1, 0};
    tbl[1] = '{3, 5, 0, 1, 0, 0, 4, 0, 0};
    tbl[2] = '{2, 3, 1, 0, 1, 6, 3, 1, 0};
    tbl[3] = '{1, 1282, 1, 1, 0, 1280, 1282, 1, 1};
    tbl[4] = '{2, 1, 1, 1, 0, 2, 1, 1, 0};
    tbl[5] = '{481, 1, 1, 1, 0, 480, 1, 1, 1};
    repeat (3) @(negedge clk_sys);
    chk_zero("reset_outputs");
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      v0 = vld_cnt;
      f0 = fd_cnt;
      run_frame(tbl[i].lines, tbl[i].bytes, tbl[i].cs, tbl[i].cm, tbl[i].vh, 0);
      chk($sformatf("row%0d_strobes", i), vld_cnt - v0, tbl[i].strobes);
      chk($sformatf("row%0d_frame_done", i), fd_cnt - f0, tbl[i].fd);
      chk($sformatf("row%0d_line_len", i), line_len, tbl[i].len);
      chk($sformatf("row%0d_ovf_err", i), ovf_err, tbl[i].ovf);
      chk($sformatf("row%0d_drain", i), vq.size() + fq.size(), 0);
    end
    // sensor stops mid-line long enough to be declared lost
    cap_en = 1;
    pcyc(0, 1, 0);
    pcyc(0, 0, 0);
    pcyc(1, 0, 8'hA1);
    pcyc(1, 0, 8'hA2);
    f0 = fd_cnt;
    repeat ((TOUS + 5) * 4) @(negedge clk_sys);
    chk("timeout_lost", ov_lost, 1);
    m_cap = 0;
    pcyc(0, 1, 0);
    chk("timeout_no_fd", fd_cnt - f0, 0);
    chk("lost_cleared", ov_lost, 0);
    v0 = vld_cnt;
    run_frame(1, 4, 1, 1, 0, 1);
    chk("resume_after_lost", vld_cnt - v0, 4);
    chk("resume_drain", vq.size() + fq.size(), 0);
    // reset in the middle of a captured line
    pcyc(0, 0, 0);
    pcyc(1, 0, 8'h55);
    pcyc(1, 0, 8'h66);
    rst = 1;
    @(posedge clk_sys);
    #1;
    chk_zero("rst_midline_outputs");
    @(negedge clk_sys);
    rst = 0;
    m_cap = 0;
    m_len = 0;
    m_ovf = 0;
    v0 = vld_cnt;
    pcyc(1, 0, 8'h77);
    pcyc(1, 0, 8'h78);
    pcyc(0, 0, 0);
    chk("rst_no_vld", vld_cnt - v0, 0);
    run_frame(1, 3, 1, 1, 0, 0);
    chk("rst_resume", vld_cnt - v0, 3);
    chk("rst_resume_len", line_len, 3);
    // random frames against the model
    for (int i = 0; i < 8; i++) begin
      nl = $urandom_range(1, 4);
      nb = $urandom_range(1, 24);
      cs = ($urandom_range(0, 3) != 0);
      cm = $urandom_range(0, 1) != 0;
      vh = $urandom_range(0, 1) != 0;
      run_frame(nl, nb, cs, cm, vh, 1);
      chk("rnd_line_len", line_len, m_len);
      chk("rnd_ovf_err", ovf_err, m_ovf);
      chk("rnd_drain", vq.size() + fq.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
